// File: rtl/control_fsm.sv
// control_fsm: FETCH/DECODE/EXEC/WB instruction sequencer with valid/ready intake, pc and register-file strobes.
// Defining RETIRE_COUNT_EN adds the retireCount output (completed-instruction counter).
module control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instrValid,
  output logic        instrReady,
  input  logic [15:0] instr,
  output logic [7:0]  pc,
  output logic [2:0]  aluControl,
  input  logic        equality,
  output logic [2:0]  rs1Addr,
  output logic [2:0]  rs2Addr,
  output logic [2:0]  rdAddr,
  output logic        regWrite
`ifdef RETIRE_COUNT_EN
  ,
  output logic [15:0] retireCount
`endif
);

  localparam logic [2:0] OP_BEQ = 3'b111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] ir_q;
  logic [7:0]  pc_q;
  logic [7:0]  pc_d;
  logic        instr_ready_q;
  logic        reg_write_q;
  logic        is_beq;
  logic [7:0]  offset_ext;

  assign is_beq     = (ir_q[15:13] == OP_BEQ);
  assign offset_ext = {{4{ir_q[3]}}, ir_q[3:0]};

  // Next pc: sequential step, or taken-branch target while a BEQ sits in EXEC.
  always_comb begin
    pc_d = pc_q + 8'd1;
    if (state_q == EXEC && is_beq && equality) begin
      pc_d = pc_q + 8'd1 + offset_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      ir_q          <= '0;
      pc_q          <= '0;
      instr_ready_q <= 1'b1;
      reg_write_q   <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (instrValid) begin
            ir_q          <= instr;
            instr_ready_q <= 1'b0;
            state_q       <= DECODE;
          end
        end
        DECODE: begin
          state_q <= EXEC;
        end
        EXEC: begin
          if (is_beq) begin
            pc_q          <= pc_d;
            instr_ready_q <= 1'b1;
            state_q       <= FETCH;
          end else begin
            reg_write_q <= 1'b1;
            state_q     <= WB;
          end
        end
        WB: begin
          pc_q          <= pc_d;
          instr_ready_q <= 1'b1;
          state_q       <= FETCH;
        end
        default: begin
          state_q       <= FETCH;
          instr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Decode fields come straight off the IR flops, so they move only when IR is loaded (entry to DECODE).
  assign aluControl = ir_q[15:13];
  assign rdAddr     = ir_q[12:10];
  assign rs1Addr    = ir_q[9:7];
  assign rs2Addr    = ir_q[6:4];
  assign pc         = pc_q;
  assign instrReady = instr_ready_q;
  assign regWrite   = reg_write_q;

`ifdef RETIRE_COUNT_EN
  logic [15:0] retire_cnt_q;
  logic [15:0] retire_cnt_d;
  logic        retire;

  assign retire = (state_q == WB) || (state_q == EXEC && is_beq);

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retireCount = retire_cnt_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: schedule-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instrValid = 1'b0;
  logic        instrReady;
  logic [15:0] instr = 16'h0;
  logic [7:0]  pc;
  logic [2:0]  aluControl;
  logic        equality = 1'b0;
  logic [2:0]  rs1Addr, rs2Addr, rdAddr;
  logic        regWrite;
`ifdef RETIRE_COUNT_EN
  logic [15:0] retireCount;
`endif

  control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instr      (instr),
    .pc         (pc),
    .aluControl (aluControl),
    .equality   (equality),
    .rs1Addr    (rs1Addr),
    .rs2Addr    (rs2Addr),
    .rdAddr     (rdAddr),
    .regWrite   (regWrite)
`ifdef RETIRE_COUNT_EN
    ,
    .retireCount(retireCount)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int accepts = 0;

  // Reference model: the in-flight instruction is described by the cycle it was accepted in;
  // every observable effect is a fixed cycle offset from that acceptance.
  int          m_acc = -1;
  logic [2:0]  m_op = 3'd0, m_rd = 3'd0, m_rs1 = 3'd0, m_rs2 = 3'd0;
  logic [3:0]  m_off = 4'd0;
  logic [7:0]  m_pc = 8'd0;
  logic [15:0] m_ret = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return (m_acc >= 0) && (cyc <= m_acc + ((m_op == 3'b111) ? 2 : 3));
  endfunction

  function automatic bit m_regwrite();
    return (m_acc >= 0) && (m_op != 3'b111) && (cyc == m_acc + 3);
  endfunction

  task automatic compare_all();
    chk("instrReady", instrReady, !m_busy());
    chk("regWrite",   regWrite,   m_regwrite());
    chk("pc",         pc,         m_pc);
    chk("aluControl", aluControl, m_op);
    chk("rs1Addr",    rs1Addr,    m_rs1);
    chk("rs2Addr",    rs2Addr,    m_rs2);
    chk("rdAddr",     rdAddr,     m_rd);
`ifdef RETIRE_COUNT_EN
    chk("retireCount", retireCount, m_ret);
`endif
  endtask

  task automatic model_advance(input logic v, input logic [15:0] ins, input logic eq);
    int s;
    bit busy;
    busy = m_busy();
    if (m_acc >= 0 && m_op == 3'b111 && cyc == m_acc + 2) begin
      s = int'(m_off);
      if (m_off[3]) s -= 16;
      m_pc  = 8'((int'(m_pc) + 1 + (eq ? s : 0)) & 255);
      m_ret = m_ret + 16'd1;
    end
    if (m_acc >= 0 && m_op != 3'b111 && cyc == m_acc + 3) begin
      m_pc  = m_pc + 8'd1;
      m_ret = m_ret + 16'd1;
    end
    if (!busy && v) begin
      m_acc = cyc;
      m_op  = ins[15:13];
      m_rd  = ins[12:10];
      m_rs1 = ins[9:7];
      m_rs2 = ins[6:4];
      m_off = ins[3:0];
    end
  endtask

  // One clock: check outputs of the current cycle, drive inputs for its closing edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic eq);
    compare_all();
    if (instrReady === 1'b1 && v) accepts++;
    instrValid = v;
    instr      = ins;
    equality   = eq;
    model_advance(v, ins, eq);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    instrValid = 1'b0;
    #1;
    chk("rst_pc",       pc,         8'd0);
    chk("rst_regWrite", regWrite,   1'b0);
    chk("rst_aluCtl",   aluControl, 3'd0);
    chk("rst_rdAddr",   rdAddr,     3'd0);
    m_acc = -1; m_pc = 8'd0; m_op = 3'd0; m_rd = 3'd0;
    m_rs1 = 3'd0; m_rs2 = 3'd0; m_off = 4'd0; m_ret = 16'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic eq);
    step(1'b1, ins, eq);
    for (int i = 0; i < 8 && instrReady !== 1'b1; i++) step(1'b0, 16'h0, eq);
    chk("run_instr_ready", instrReady, 1'b1);
  endtask

  function automatic logic [15:0] rand_alu();
    logic [2:0]  op;
    logic [12:0] rest;
    op   = 3'($urandom_range(0, 6));
    rest = 13'($urandom);
    return {op, rest};
  endfunction

  initial begin
    @(negedge clk);
    do_reset();

    // ADD rd1, rs2, rs4 with literal timing
    step(1'b1, 16'h0540, 1'b0);
    chk("add_aluCtl_N1", aluControl, 3'd0);
    chk("add_rs1_N1",    rs1Addr,    3'd2);
    chk("add_rs2_N1",    rs2Addr,    3'd4);
    chk("add_ready_N1",  instrReady, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("add_rw_N3",     regWrite,   1'b1);
    chk("add_rd_N3",     rdAddr,     3'd1);
    step(1'b0, 16'h0, 1'b0);
    chk("add_pc_N4",     pc,         8'd1);
    chk("add_ready_N4",  instrReady, 1'b1);

    // Branch forward from pc=10
    for (int i = 0; i < 9; i++) run_instr(rand_alu(), 1'b0);
    chk("pc_before_beq", pc, 8'd10);
    run_instr(16'hE003, 1'b1);
    chk("beq_taken_pc", pc, 8'd14);
    run_instr(16'hE003, 1'b0);
    chk("beq_not_taken_pc", pc, 8'd15);

    // Backward branch wrap and pc overflow
    do_reset();
    run_instr(rand_alu(), 1'b0);
    run_instr(rand_alu(), 1'b0);
    run_instr(16'hE008, 1'b1);
    chk("beq_neg8_pc", pc, 8'd251);
    for (int i = 0; i < 4; i++) run_instr(rand_alu(), 1'b0);
    chk("pc_255", pc, 8'd255);
    run_instr(16'h2A50, 1'b0);
    chk("sub_wrap_pc", pc, 8'd0);

    // instrValid held high: one accept per four cycles
    accepts = 0;
    for (int i = 0; i < 12; i++) step(1'b1, rand_alu(), 1'b0);
    chk("back_to_back_accepts", accepts, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0);

    // Reset during EXEC aborts the ADD
    step(1'b1, 16'h0540, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    do_reset();
    chk("abort_pc",    pc,         8'd0);
    chk("abort_ready", instrReady, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_rw", regWrite, 1'b0);
      step(1'b0, 16'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) run_instr(rand_alu(), 1'b0);
    run_instr(16'hE001, 1'b0);
`ifdef RETIRE_COUNT_EN
    chk("retire_5", retireCount, 16'd5);
`endif
    chk("pc_after_5", pc, 8'd5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
